if_prefetch: RTL and testbench
==============================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction buffer entries and max outstanding requests.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port pc_mux_sel  in  pc_mux_t  PC_NEXT: sequential fetch; PC_BRANCH: redirect this cycle.
REQ-006 SHALL have port branch_target  in  32  redirect address, sampled when pc_mux_sel==PC_BRANCH.
REQ-007 SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-008 SHALL have port imem_addr  out  32  fetch address, bits[1:0] always 0.
REQ-009 SHALL have port imem_gnt  in  1  request accepted this cycle.
REQ-010 SHALL have port imem_rvalid  in  1  in-order response valid.
REQ-011 SHALL have port imem_rdata  in  32  response instruction word.
REQ-012 SHALL have port instr_valid  out  1  buffer head valid toward decoder.
REQ-013 SHALL have port instr  out  32  buffer head instruction.
REQ-014 SHALL have port instr_pc  out  32  address of instr.
REQ-015 SHALL have port instr_ready  in  1  decoder consumes head when instr_valid && instr_ready.

Function
REQ-016 SHALL keep fetch_pc, outstanding count (0..DEPTH), discard count, FIFO of {instr, pc}.
REQ-017 SHALL use FSM states FETCH (req allowed) and HOLD (req asserted, awaiting gnt).
REQ-018 SHALL assert imem_req in FETCH iff FIFO occupancy + outstanding < DEPTH; then go to HOLD if imem_gnt=0.
REQ-019 SHALL hold imem_req=1 and imem_addr stable in HOLD until imem_gnt, except on redirect.
REQ-020 SHALL on imem_req&&imem_gnt advance fetch_pc by 4 (mod 2^32, wraps 32'hFFFF_FFFC->0) and increment outstanding.
REQ-021 SHALL on imem_rvalid decrement outstanding; if discard>0 drop word and decrement discard, else push {imem_rdata, pc} into FIFO.
REQ-022 SHALL present pushed word at instr_valid one cycle after imem_rvalid (registered FIFO).
REQ-023 SHALL allow simultaneous push and pop in one cycle; occupancy unchanged.
REQ-024 SHALL hold instr/instr_pc stable while instr_valid && !instr_ready.
REQ-025 SHALL on redirect: clear FIFO, set fetch_pc to {branch_target[31:2],2'b00}, set discard to requests in flight after this cycle's gnt/rvalid, FSM to FETCH; request to target issued next cycle.
REQ-026 SHALL give redirect priority over every simultaneous event; a same-cycle gnt is counted as discarded; a same-cycle pop completes normally.
REQ-027 SHALL never push when FIFO full (guaranteed by REQ-018); an rvalid with outstanding==0 is a protocol error, ignored.

Reset
REQ-028 SHALL on reset==0 at clk edge set fetch_pc=RESET_PC, outstanding=0, discard=0, FIFO empty, FSM=FETCH.
REQ-029 SHALL drive during reset imem_req=0, instr_valid=0, imem_addr=RESET_PC, instr=0, instr_pc=0.
REQ-030 SHALL on reset mid-operation drop all in-flight responses (the memory is reset together with the block).
REQ-031 SHALL issue first request in the first cycle after reset deasserts.

Configuration
REQ-032 SHALL with IF_BYPASS_EN defined forward imem_rdata/pc combinationally to instr/instr_pc when FIFO empty, discard==0, imem_rvalid=1, no redirect; if instr_ready that cycle, word not pushed.
REQ-033 SHALL without IF_BYPASS_EN have response-to-instr_valid latency of exactly one cycle.

Structure
REQ-034 SHALL take pc_mux_t and word from decoder_pkg; IF_DEPTH_DEFAULT and IF_RESET_PC constants added there.
REQ-035 SHALL implement the buffer as sub-module fetch_fifo (parameterised depth, push/pop/full/empty, synchronous clear).

Verification
REQ-036 Reset, gnt=1 always, rvalid one cycle after gnt -> addrs 0,4,8...; instr_valid first high 3 cycles after reset release.
REQ-037 instr_ready=0 for 10 cycles -> exactly DEPTH=2 requests issued, imem_req low after, instr/instr_pc stay {word@0, 0}.
REQ-038 Redirect to 32'h0000_0103 with 2 outstanding -> next imem_addr 32'h100; two following rvalids dropped; first instr_pc 32'h100.
REQ-039 gnt held low 5 cycles -> imem_req and imem_addr constant; on gnt fetch_pc advances exactly 4.
REQ-040 RESET_PC=32'hFFFF_FFF8 -> addrs FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 IF_BYPASS_EN, empty FIFO, instr_ready=1, rvalid with 32'h0000_0013 -> instr=32'h0000_0013 same cycle.

Source files
------------

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_pkg
//  Description : Shared types and constants for the fetch front end.
//                pc_mux_t selects sequential fetch or a branch redirect,
//                word is the 32-bit machine word, if_state_t is the request
//                FSM encoding and if_entry_t is one instruction-buffer entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    typedef logic [31:0] word;

    typedef enum logic [0:0] {
        PC_NEXT   = 1'b0,
        PC_BRANCH = 1'b1
    } pc_mux_t;

    // Default instruction-buffer depth and boot address of the fetch unit
    localparam int unsigned IF_DEPTH_DEFAULT = 2;
    localparam word         IF_RESET_PC      = 32'h0000_0000;

    // FETCH: a request may be raised; HOLD: a request is pending its grant
    typedef enum logic [0:0] {
        IF_FETCH = 1'b0,
        IF_HOLD  = 1'b1
    } if_state_t;

    typedef struct packed {
        word instr;
        word pc;
    } if_entry_t;

    // Word-align an address (fetch addresses never carry byte offsets)
    function automatic word if_align(input word a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Circular instruction buffer of DEPTH {instr, pc} entries.
//                Head is read straight from the storage registers, so a word
//                pushed on one edge is visible at o_head after that edge.
//  Ports       : clk      - clock
//                reset    - synchronous, active-low reset
//                i_clear  - synchronous flush (redirect)
//                i_push   - write i_data at the tail
//                i_data   - entry to write
//                i_pop    - retire the head entry
//                o_head   - current head entry
//                o_empty  - no entries stored
//                o_full   - DEPTH entries stored
//                o_count  - number of entries stored
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import decoder_pkg::*;
#(
    parameter int unsigned DEPTH = IF_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  if_entry_t                    i_data,
    input  logic                         i_pop,
    output if_entry_t                    o_head,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned         CW     = $clog2(DEPTH + 1);
    localparam int unsigned         PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]       c_last = PW'(DEPTH - 1);
    localparam logic [CW-1:0]       c_full = CW'(DEPTH);
    localparam logic [CW-1:0]       c_one  = CW'(1);

    if_entry_t        r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == c_last) ? '0 : p + PW'(1);
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_full);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

    assign w_pop  = i_pop && !o_empty;
    // A full buffer can still accept a word when the head leaves this cycle
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= ptr_inc(r_wr);
            if (w_pop)  r_rd <= ptr_inc(r_rd);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed below r_count
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch
//  Description : Instruction prefetch unit. Issues sequential word fetches to
//                instruction memory, keeps at most DEPTH words either in
//                flight or buffered, and hands them in order to the decoder.
//                A branch redirect flushes the buffer and marks every request
//                still in flight to be dropped on return.
//  Option      : IF_BYPASS_EN - when defined, a returning word is forwarded
//                combinationally to instr/instr_pc if the buffer is empty.
//  Ports       : clk           - clock
//                reset         - synchronous, active-low reset
//                pc_mux_sel    - PC_NEXT sequential / PC_BRANCH redirect
//                branch_target - redirect address
//                imem_req      - fetch request
//                imem_addr     - fetch address (word aligned)
//                imem_gnt      - request accepted
//                imem_rvalid   - in-order response valid
//                imem_rdata    - response instruction word
//                instr_valid   - buffer head valid
//                instr         - buffer head instruction
//                instr_pc      - address of instr
//                instr_ready   - decoder consumes the head
//  Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch
    import decoder_pkg::*;
#(
    parameter word         RESET_PC = IF_RESET_PC,
    parameter int unsigned DEPTH    = IF_DEPTH_DEFAULT
) (
    input  logic    clk,
    input  logic    reset,
    input  pc_mux_t pc_mux_sel,
    input  word     branch_target,
    output logic    imem_req,
    output word     imem_addr,
    input  logic    imem_gnt,
    input  logic    imem_rvalid,
    input  word     imem_rdata,
    output logic    instr_valid,
    output word     instr,
    output word     instr_pc,
    input  logic    instr_ready
);

    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   c_depth = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] c_one   = CW'(1);

    if_state_t     r_state;
    if_state_t     w_state_nxt;
    word           r_fetch_pc;
    word           r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] w_out_nxt;

    logic          w_redirect;
    word           w_target;
    logic          w_room;
    logic          w_req;
    logic          w_fire;
    logic          w_rsp;
    logic          w_rsp_keep;
    logic          w_push;
    logic          w_pop;
    logic          w_head_valid;
    if_entry_t     w_head;
    if_entry_t     w_rsp_entry;

    if_entry_t     w_fifo_head;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic [CW-1:0] w_fifo_count;

    assign w_redirect  = (pc_mux_sel == PC_BRANCH);
    assign w_target    = if_align(branch_target);
    // Buffered words and requests in flight share the DEPTH budget, so a
    // response always finds a free slot
    assign w_room      = ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < c_depth;
    assign w_req       = (r_state == IF_HOLD) || w_room;
    assign w_fire      = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored
    assign w_rsp       = imem_rvalid && (r_outstanding != '0);
    assign w_rsp_keep  = w_rsp && (r_discard == '0) && !w_redirect;
    assign w_rsp_entry = '{instr: imem_rdata, pc: r_resp_pc};
    assign w_pop       = instr_valid && instr_ready && !w_fifo_empty;

`ifdef IF_BYPASS_EN
    logic w_bypass;
    assign w_bypass     = w_rsp_keep && w_fifo_empty;
    assign w_head_valid = !w_fifo_empty || w_bypass;
    assign w_head       = w_bypass ? w_rsp_entry : w_fifo_head;
    // A forwarded word that the decoder takes at once never enters the buffer
    assign w_push       = w_rsp_keep && !w_fifo_full && !(w_bypass && instr_ready);
`else
    assign w_head_valid = !w_fifo_empty;
    assign w_head       = w_fifo_head;
    assign w_push       = w_rsp_keep && !w_fifo_full;
`endif

    // Outputs are forced to their idle values while reset is held
    assign imem_req    = reset && w_req;
    assign imem_addr   = reset ? r_fetch_pc : RESET_PC;
    assign instr_valid = reset && w_head_valid;
    assign instr       = reset ? w_head.instr : '0;
    assign instr_pc    = reset ? w_head.pc    : '0;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_redirect),
        .i_push  (w_push),
        .i_data  (w_rsp_entry),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IF_FETCH;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IF_FETCH: if (imem_req && !imem_gnt) w_state_nxt = IF_HOLD;
            IF_HOLD:  if (imem_gnt)              w_state_nxt = IF_FETCH;
            default:                             w_state_nxt = IF_FETCH;
        endcase
        if (w_redirect) w_state_nxt = IF_FETCH;
    end

    // ------------------------------------------------------------------
    // Fetch / response bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_fire) w_out_nxt = w_out_nxt + c_one;
        if (w_rsp)  w_out_nxt = w_out_nxt - c_one;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                // Everything still in flight after this edge is stale,
                // including a request granted in this very cycle
                r_discard  <= w_out_nxt;
            end else begin
                if (w_fire)     r_fetch_pc <= r_fetch_pc + 32'd4;
                // Responses return in order, so the next kept word is
                // always at the address following the previous kept word
                if (w_rsp_keep) r_resp_pc  <= r_resp_pc + 32'd4;
                if (w_rsp && (r_discard != '0)) r_discard <= r_discard - c_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_if_prefetch
//  Description : Self-checking bench for if_prefetch. A memory model answers
//                granted requests in order after a random latency; a
//                reference model tracks the expected fetch address, the
//                expected decoder-visible instruction stream, buffer
//                occupancy and request epochs (redirects make older epochs
//                stale). A second instance checks address wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch;
    import decoder_pkg::*;

    localparam int          DEPTH   = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    pc_mux_t     pc_mux_sel;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic        w2_req;
    logic        w2_valid;
    logic [31:0] w2_addr;
    logic [31:0] w2_instr;
    logic [31:0] w2_pc;
    pc_mux_t     w2_sel    = PC_NEXT;
    logic        w2_gnt    = 1'b1;
    logic        w2_rvalid = 1'b0;
    logic [31:0] w2_rdata  = '0;
    logic        w2_ready  = 1'b1;
    logic [31:0] w2_tgt    = '0;

    if_prefetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .pc_mux_sel(pc_mux_sel), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    if_prefetch #(.RESET_PC(WRAP_PC), .DEPTH(4)) u_wrap (
        .clk(clk), .reset(reset), .pc_mux_sel(w2_sel), .branch_target(w2_tgt),
        .imem_req(w2_req), .imem_addr(w2_addr), .imem_gnt(w2_gnt),
        .imem_rvalid(w2_rvalid), .imem_rdata(w2_rdata),
        .instr_valid(w2_valid), .instr(w2_instr), .instr_pc(w2_pc), .instr_ready(w2_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // stimulus controls
    bit          rst_cmd   = 1'b0;
    bit          redir_cmd = 1'b0;
    logic [31:0] tgt_cmd   = '0;
    int          gnt_pct   = 100;
    int          rdy_pct   = 100;
    int          lat_min   = 1;
    int          lat_max   = 1;
    bit          rv_en     = 1'b1;

    // reference model
    pend_t       pend[$];
    int          epoch     = 0;
    int          occ       = 0;
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] exp_pc    = RST_PC;
    bit          in_hold   = 1'b0;
    int          n_dropped = 0;

    // values sampled in the last cycle
    logic        s_req, s_gnt, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_0013;
    endfunction

    // One clock cycle: drive at the falling edge, sample 1ns later, then
    // update the model with what the coming rising edge will commit.
    task automatic cycle();
        bit          keep;
        bit          exp_v;
        bit          exp_req;
        @(negedge clk);
        reset         = rst_cmd;
        pc_mux_sel    = redir_cmd ? PC_BRANCH : PC_NEXT;
        branch_target = tgt_cmd;
        imem_gnt      = ($urandom_range(99) < gnt_pct);
        instr_ready   = ($urandom_range(99) < rdy_pct);
        imem_rvalid   = 1'b0;
        imem_rdata    = $urandom;
        if (rst_cmd && rv_en && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
        end
        #1;
        s_req = imem_req; s_gnt = imem_gnt; s_valid = instr_valid;
        s_addr = imem_addr; s_instr = instr; s_pc = instr_pc;
        if (!rst_cmd) begin
            n_checks++;
            if ({imem_req, instr_valid, imem_addr, instr, instr_pc} !== {1'b0, 1'b0, RST_PC, 32'h0, 32'h0})
                $display("FAIL reset_outputs cyc=%0d: got req=%b valid=%b addr=%h instr=%h pc=%h expected 0 0 %h 0 0",
                         cyc, imem_req, instr_valid, imem_addr, instr, instr_pc, RST_PC);
            else n_pass++;
            pend.delete();
            occ = 0; epoch++; exp_fetch = RST_PC; exp_pc = RST_PC; in_hold = 1'b0;
        end else begin
            keep = 1'b0;
            if (imem_rvalid) keep = (pend[0].epoch == epoch) && !redir_cmd;

            exp_req = in_hold ? 1'b1 : ((occ + pend.size()) < DEPTH);
            n_checks++;
            if (imem_req !== exp_req)
                $display("FAIL imem_req cyc=%0d: got %b expected %b (occ=%0d inflight=%0d)",
                         cyc, imem_req, exp_req, occ, pend.size());
            else n_pass++;

            if (imem_req) begin
                n_checks++;
                if (imem_addr !== exp_fetch)
                    $display("FAIL imem_addr cyc=%0d: got %h expected %h", cyc, imem_addr, exp_fetch);
                else n_pass++;
            end

            exp_v = (occ > 0);
`ifdef IF_BYPASS_EN
            if (keep && occ == 0) exp_v = 1'b1;
`endif
            n_checks++;
            if (instr_valid !== exp_v)
                $display("FAIL instr_valid cyc=%0d: got %b expected %b", cyc, instr_valid, exp_v);
            else n_pass++;

            if (instr_valid) begin
                n_checks++;
                if ({instr_pc, instr} !== {exp_pc, mem_word(exp_pc)})
                    $display("FAIL instr_head cyc=%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                             cyc, instr_pc, instr, exp_pc, mem_word(exp_pc));
                else n_pass++;
            end

            if (imem_rvalid) begin
                pend.delete(0);
                if (keep) occ++;
                else      n_dropped++;
            end
            if (imem_req && imem_gnt) begin
                pend.push_back('{addr: imem_addr, epoch: epoch,
                                 due: cyc + int'($urandom_range(lat_max, lat_min))});
                exp_fetch += 32'd4;
            end
            if (instr_valid && instr_ready) begin
                occ--;
                exp_pc += 32'd4;
            end
            in_hold = imem_req && !imem_gnt;
            if (redir_cmd) begin
                epoch++;
                occ       = 0;
                exp_fetch = tgt_cmd & 32'hFFFF_FFFC;
                exp_pc    = tgt_cmd & 32'hFFFF_FFFC;
                in_hold   = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic apply_reset(input int n);
        rst_cmd   = 1'b0;
        redir_cmd = 1'b0;
        repeat (n) cycle();
        rst_cmd   = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(3);
        n_checks++;
        if ({w2_req, w2_valid, w2_addr} !== {1'b0, 1'b0, WRAP_PC})
            $display("FAIL wrap_reset: got req=%b valid=%b addr=%h expected 0 0 %h", w2_req, w2_valid, w2_addr, WRAP_PC);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] addrs[$];
        logic [31:0] exp_a;
        apply_reset(2);
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1; rv_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_req && s_gnt) addrs.push_back(s_addr);
            if (i == 0) begin
                n_checks++;
                if (s_valid !== 1'b0) $display("FAIL stream_valid_c0: got %b expected 0", s_valid);
                else n_pass++;
            end
            if (i == 1) begin
                n_checks++;
`ifdef IF_BYPASS_EN
                if ({s_valid, s_instr} !== {1'b1, 32'h0000_0013})
                    $display("FAIL bypass_same_cycle: got valid=%b instr=%h expected 1 00000013", s_valid, s_instr);
                else n_pass++;
`else
                if (s_valid !== 1'b0) $display("FAIL stream_valid_c1: got %b expected 0", s_valid);
                else n_pass++;
`endif
            end
            if (i == 2) begin
                n_checks++;
`ifdef IF_BYPASS_EN
                if ({s_valid, s_pc} !== {1'b1, 32'h4})
                    $display("FAIL stream_valid_c2: got valid=%b pc=%h expected 1 00000004", s_valid, s_pc);
                else n_pass++;
`else
                if ({s_valid, s_pc, s_instr} !== {1'b1, 32'h0, 32'h0000_0013})
                    $display("FAIL stream_valid_c2: got valid=%b pc=%h instr=%h expected 1 00000000 00000013",
                             s_valid, s_pc, s_instr);
                else n_pass++;
`endif
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp_a = 32'(i * 4);
            n_checks++;
            if (addrs.size() <= i) $display("FAIL stream_addr%0d: got none expected %h", i, exp_a);
            else if (addrs[i] !== exp_a) $display("FAIL stream_addr%0d: got %h expected %h", i, addrs[i], exp_a);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        int grants = 0;
        apply_reset(2);
        gnt_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1; rv_en = 1'b1;
        repeat (10) begin
            cycle();
            if (s_req && s_gnt) grants++;
        end
        n_checks++;
        if (grants !== DEPTH) $display("FAIL stall_grants: got %0d expected %0d", grants, DEPTH);
        else n_pass++;
        n_checks++;
        if ({s_req, s_valid, s_instr, s_pc} !== {1'b0, 1'b1, 32'h0000_0013, 32'h0})
            $display("FAIL stall_head: got req=%b valid=%b instr=%h pc=%h expected 0 1 00000013 00000000",
                     s_req, s_valid, s_instr, s_pc);
        else n_pass++;
        rdy_pct = 100;
    endtask

    task automatic test_redirect();
        bit seen = 1'b0;
        apply_reset(2);
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1; rv_en = 1'b0;
        repeat (3) cycle();
        n_checks++;
        if (pend.size() !== 2 || s_req !== 1'b0)
            $display("FAIL redirect_setup: got inflight=%0d req=%b expected 2 0", pend.size(), s_req);
        else n_pass++;
        redir_cmd = 1'b1; tgt_cmd = 32'h0000_0103;
        cycle();
        redir_cmd = 1'b0;
        cycle();
        // both stale requests still occupy the budget, so only the address moves
        n_checks++;
        if (s_addr !== 32'h0000_0100) $display("FAIL redirect_addr: got %h expected 00000100", s_addr);
        else n_pass++;
        n_dropped = 0;
        rv_en = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (s_valid) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL redirect_timeout: got no instr_valid expected one within 20 cycles");
        else if ({s_pc, n_dropped} !== {32'h0000_0100, 32'd2})
            $display("FAIL redirect_first: got pc=%h dropped=%0d expected 00000100 2", s_pc, n_dropped);
        else n_pass++;
    endtask

    task automatic test_gnt_hold();
        apply_reset(2);
        gnt_pct = 0; rdy_pct = 100; lat_min = 1; lat_max = 1; rv_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if ({s_req, s_addr} !== {1'b1, RST_PC})
                $display("FAIL hold_c%0d: got req=%b addr=%h expected 1 %h", i, s_req, s_addr, RST_PC);
            else n_pass++;
        end
        gnt_pct = 100;
        cycle();
        cycle();
        n_checks++;
        if (s_addr !== RST_PC + 32'd4) $display("FAIL hold_advance: got %h expected %h", s_addr, RST_PC + 32'd4);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w [4];
        exp_w = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        apply_reset(2);
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if ({w2_req, w2_addr} !== {1'b1, exp_w[i]})
                $display("FAIL wrap_addr%0d: got req=%b addr=%h expected 1 %h", i, w2_req, w2_addr, exp_w[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        apply_reset(2);
        for (int ph = 0; ph < 3; ph++) begin
            case (ph)
                0:       begin gnt_pct = 70;  rdy_pct = 60; lat_min = 1; lat_max = 3; end
                1:       begin gnt_pct = 100; rdy_pct = 90; lat_min = 1; lat_max = 1; end
                default: begin gnt_pct = 40;  rdy_pct = 30; lat_min = 1; lat_max = 5; end
            endcase
            rv_en = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                redir_cmd = ($urandom_range(99) < 3);
                tgt_cmd   = $urandom;
                rst_cmd   = ($urandom_range(999) >= 5);
                cycle();
            end
        end
        redir_cmd = 1'b0;
        rst_cmd   = 1'b1;
    endtask

    initial begin
        reset = 1'b0; pc_mux_sel = PC_NEXT; branch_target = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_gnt_hold();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1);
    end

endmodule
`default_nettype wire
